// File: rtl/usb_uart_pkg.sv
// Shared constants and types for the USB UART transmit path.
package usb_uart_pkg;

    localparam int unsigned DEPTH_LOG2_DEFAULT = 6;
    localparam int unsigned DROP_COUNT_W       = 16;

    // Output register occupancy.
    typedef enum logic {
        OutEmpty,
        OutFull
    } out_state_e;

endpackage

// File: rtl/usb_uart_fifo_ram.sv
// Simple dual-port RAM with a registered read port.
// The array has no reset so that it maps onto iCE40 block RAM.
module usb_uart_fifo_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Write port and registered read port; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/usb_uart_tx_fifo.sv
// Byte FIFO between the CPU's write strobes and the USB UART core's IN pipe.
// Memory entries stay counted in mem_count until they move into the output
// register, so a byte sitting in the RAM read register (prefetch) is still
// part of the memory count and capacity is DEPTH + 1.
module usb_uart_tx_fifo
    import usb_uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                    clk_48mhz,
    input  logic                    reset,
    input  logic [7:0]              wr_data,
    input  logic                    wr_en,
    output logic                    wr_full,
    input  logic                    flush,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overflow,
    output logic [DROP_COUNT_W-1:0] drop_count,
    input  logic                    ovf_clear,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned      PTR_W     = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(1 << DEPTH_LOG2);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      mem_count, mem_count_d;
    logic                  pf_valid_q, pf_valid_d;
    out_state_e            state_q, state_d;
    logic                  pop, pf_move, rd_issue, wr_accept, wr_reject;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [7:0]            ram_rdata;

    assign out_valid = (state_q == OutFull);

    // Pointer arithmetic, write acceptance and prefetch control.
    always_comb begin
        mem_count = wr_ptr_q - rd_ptr_q;
        pop       = out_valid && out_ready;
        // Prefetched byte moves to the output register when it is free or popping.
        pf_move   = pf_valid_q && (!out_valid || pop);
        wr_accept = wr_en && !flush && (mem_count < DEPTH_CNT);
        wr_reject = wr_en && !flush && (mem_count >= DEPTH_CNT);
        // Read the next unfetched entry when the prefetch slot is free this cycle.
        rd_issue  = !flush && (mem_count > PTR_W'(pf_valid_q)) && (!pf_valid_q || pf_move);
        rd_addr   = rd_ptr_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(pf_valid_q);

        wr_ptr_d   = flush ? '0 : wr_ptr_q + PTR_W'(wr_accept);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + PTR_W'(pf_move);
        pf_valid_d = pf_valid_q;
        if (flush) begin
            pf_valid_d = 1'b0;
        end else if (rd_issue) begin
            pf_valid_d = 1'b1;
        end else if (pf_move) begin
            pf_valid_d = 1'b0;
        end
        mem_count_d = wr_ptr_d - rd_ptr_d;
    end

    // Output register next state; a pop during flush counts as completed.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OutEmpty;
        end else begin
            unique case (state_q)
                OutEmpty: if (pf_move)         state_d = OutFull;
                OutFull:  if (pop && !pf_move) state_d = OutEmpty;
                default:                       state_d = OutEmpty;
            endcase
        end
    end

    // Pointer, prefetch, output register and registered status state.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pf_valid_q <= 1'b0;
            state_q    <= OutEmpty;
            out_data   <= 8'h00;
            level      <= '0;
            wr_full    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pf_valid_q <= pf_valid_d;
            state_q    <= state_d;
            if (!flush && pf_move) begin
                out_data <= ram_rdata;
            end
            level   <= mem_count_d + PTR_W'(state_d == OutFull);
            wr_full <= (mem_count_d == DEPTH_CNT);
        end
    end

    // Sticky overflow and saturating drop counter; a rejected write beats clear.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (wr_reject) begin
            overflow <= 1'b1;
            if (ovf_clear) begin
                drop_count <= DROP_COUNT_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (ovf_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    usb_uart_fifo_ram #(
        .ADDR_W(DEPTH_LOG2),
        .DATA_W(8)
    ) u_ram (
        .clk  (clk_48mhz),
        .we   (wr_accept),
        .waddr(wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata(wr_data),
        .re   (rd_issue),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

endmodule

// File: doc/usb_uart_tx_fifo.md
# usb_uart_tx_fifo

Byte FIFO that sits directly upstream of `usb_uart_core`'s uart-in pipe. It absorbs the application's (j1eforth CPU) fire-and-forget write strobes and presents them as a valid/ready stream on `uart_in_data`/`uart_in_valid`/`uart_in_ready`. This decouples CPU output from USB IN-transaction pacing. Rejected writes are counted and flagged, and the queue can be flushed, e.g. on host-presence loss.

## Interface
- `DEPTH_LOG2`, default 6: storage memory holds 2^DEPTH_LOG2 bytes (DEPTH); total capacity is DEPTH+1, including the output register.
- `clk_48mhz` in, 1: sole clock.
- `reset` in, 1: asynchronous, active-high reset.
- `wr_data` in, 8: byte from the application.
- `wr_en` in, 1: write strobe; no back-pressure, so the caller checks `wr_full`.
- `wr_full` out, 1: memory full; a write this cycle is rejected.
- `flush` in, 1: synchronous single-cycle discard of all contents.
- `level` out, DEPTH_LOG2+1: bytes held (memory count + `out_valid`), 0..DEPTH+1.
- `overflow` out, 1: sticky; set by a rejected write.
- `drop_count` out, 16: saturating count of rejected writes.
- `ovf_clear` in, 1: clears `overflow` and `drop_count`.
- `out_data` out, 8: connects to core `uart_in_data`.
- `out_valid` out, 1: connects to core `uart_in_valid`.
- `out_ready` in, 1: connects to core `uart_in_ready`.

## Operation
- **Storage:** DEPTH×8 memory with a registered (synchronous) read, suitable for iCE40 BRAM.
  - `wr_ptr`/`rd_ptr` are DEPTH_LOG2+1 bits; the extra bit distinguishes full from empty.
  - `mem_count = wr_ptr - rd_ptr`, computed modulo 2^(DEPTH_LOG2+1).
  - Pointers wrap naturally at 2^DEPTH_LOG2 for addressing.
- **Write acceptance:** a write is accepted iff `wr_en && !flush && mem_count < DEPTH`, judged at the start of the cycle.
  - A write while full is rejected even if a pop frees space in the same cycle.
- **Rejected write:** sets `overflow` and increments `drop_count`, saturating at 0xFFFF.
  - If `ovf_clear` is asserted in the same cycle, the set wins: `overflow`=1 and `drop_count`=1.
- **Output stage:** show-ahead output register in two states.
  - EMPTY (`out_valid`=0), FULL (`out_valid`=1).
  - A pop occurs on `out_valid && out_ready`.
  - Refill: when the output register is empty or popping this cycle, and `mem_count` > 0, issue a memory read and advance `rd_ptr`. Read data lands in `out_data` with `out_valid`=1 at the next edge.
  - The read is pipelined so back-to-back pops with a non-empty memory sustain one byte per cycle. This needs a one-entry prefetch/skid inside the stage.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **Flush:** clears `wr_ptr`, `rd_ptr`, `out_valid` and any prefetch at the next edge.
  - Leaves `overflow` and `drop_count` untouched.
  - A simultaneous write is discarded silently and not counted.
  - A simultaneous pop is treated as completed.
- **Outputs:** `level` and `wr_full` are registered and consistent with the state after each edge.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `wr_full`=0, `level`=0, `overflow`=0, `drop_count`=0, pointers 0.
- **Latency:** a write at edge k into an empty FIFO gives `out_valid`=1 after edge k+2 (one memory read cycle).
- **Throughput:** one write and one pop per cycle, sustained; a simultaneous write and pop leaves `level` unchanged.
- **Full:** `wr_full` rises the edge after the DEPTH-th memory entry is written. It falls the edge after a refill frees an entry.
- **Reset mid-transfer:** `out_valid` drops asynchronously. The core sees no further bytes, and the partial USB packet is the core's concern.

## Structure
- Shared package `usb_uart_pkg`: `DEPTH_LOG2` default and the `DROP_COUNT_W`=16 constant.
- Sub-module `usb_uart_fifo_ram`: parameterised simple dual-port RAM, registered read, no reset on the array.
- Top: pointer/count logic, output stage, overflow/drop logic.

## Test plan
- **Reset then idle:** all outputs 0 and `level`=0 for 10 cycles.
- **Fill and drain:** write 0x41..0x80 (64 bytes, `out_ready`=0) → `level`=65 is impossible; the 65th write is accepted into the output register.
  - Writing 66 bytes → `wr_full`=1, `overflow`=1, `drop_count`=1.
  - Draining gives 0x41.. in order, with no gaps while `out_ready`=1.
- **Streaming:** 1000 random bytes, `wr_en` 50% duty, `out_ready` toggling randomly → output sequence equals the input sequence, `level` never exceeds 65, `overflow`=0.
- **Stall hold:** with `out_valid`=1 and `out_data`=0x5A, hold `out_ready`=0 for 7 cycles → `out_data` stays 0x5A; the pop on cycle 8 presents the next byte on the following cycle.
- **Flush mid-stream:** 20 bytes queued, flush together with a write of 0x33 → next edge `level`=0, `out_valid`=0; 0x33 never appears; `drop_count` unchanged.
- **Overflow clear priority:** full FIFO, `ovf_clear` and a rejected `wr_en` in the same cycle → `overflow`=1, `drop_count`=1. The next cycle with `ovf_clear` alone → both 0.
